uart_tx_arbiter: RTL

Sequencer and two-port round-robin arbiter for the transmit side of `UART_controller`. It lets two requesters share the one 32-bit UART TX path, for example the MIPS core's memory-mapped UART port and a debug/monitor source. For each granted word the block latches the data, pulses `Start_Tx` and waits for `Tx_flag_out`. It then clears the flag with `clr_tx_flag` and returns a one-cycle `ack` to the owner. A timeout guards against a stuck transmitter.

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-port round-robin arbiter and sequencer for the UART_controller transmit path.
// It latches the granted word, pulses Start_Tx, waits for Tx_flag_out with a timeout, clears the flag and acks the owner.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TX_TIMEOUT = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic                  Tx_flag_out,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  timeout_err,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] uart_tx,
  output logic                  Start_Tx,
  output logic                  clr_tx_flag
);

  localparam int CW = $clog2(TX_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_START,
    S_WAIT,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [1:0]            r_grant;
  logic [DATA_WIDTH-1:0] r_uart_tx;
  logic                  r_start;
  logic                  r_clr;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_terr;
  logic                  r_busy;
  logic                  r_last;
  logic                  r_abort;
  logic [CW-1:0]         r_cnt;
  logic                  w_pick0;

  // On a tie, requester 0 wins only when requester 1 was served last.
  assign w_pick0 = req0 & (~req1 | r_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_grant   <= 2'b00;
      r_uart_tx <= '0;
      r_start   <= 1'b0;
      r_clr     <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_terr    <= 1'b0;
      r_busy    <= 1'b0;
      r_last    <= 1'b1;
      r_abort   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_start <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_terr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_grant   <= w_pick0 ? 2'b01 : 2'b10;
            r_uart_tx <= w_pick0 ? data0 : data1;
            r_busy    <= 1'b1;
            if (Tx_flag_out) begin
              r_state <= S_FLUSH;
              r_clr   <= 1'b1;
            end else begin
              r_state <= S_START;
              r_start <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (!Tx_flag_out) begin
            r_state <= S_START;
            r_clr   <= 1'b0;
            r_start <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
        // A flag arriving on the timeout cycle still counts as a clean completion.
        S_WAIT: begin
          if (Tx_flag_out) begin
            r_state <= S_CLEAR;
            r_clr   <= 1'b1;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= S_CLEAR;
            r_clr   <= 1'b1;
            r_abort <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CLEAR: begin
          if (!Tx_flag_out) begin
            r_state <= S_DONE;
            r_clr   <= 1'b0;
            r_ack0  <= r_grant[0];
            r_ack1  <= r_grant[1];
            r_terr  <= r_abort;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_last  <= r_grant[1];
          r_grant <= 2'b00;
          r_abort <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign timeout_err = r_terr;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign uart_tx     = r_uart_tx;
  assign Start_Tx    = r_start;
  assign clr_tx_flag = r_clr;

endmodule
